// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 encodings and the write-responder FSM state type.
package axi4_globals_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } burst_t;

  typedef enum logic [2:0] {
    SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
  } size_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi4_burst_addr_gen
  import axi4_globals_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [2:0]               size,
  input  logic [7:0]               len,
  input  logic [1:0]               burst,
  output logic [ADDRESS_WIDTH-1:0] next_addr
);
  logic [ADDRESS_WIDTH-1:0] w_step, w_mask, w_incr;

  assign w_step = ADDRESS_WIDTH'(1) << size;
  // Wrap window is (len+1) beats; only meaningful when that is a power of two.
  assign w_mask = ((ADDRESS_WIDTH'(len) + ADDRESS_WIDTH'(1)) << size) - ADDRESS_WIDTH'(1);
  assign w_incr = addr + w_step;

  always_comb begin
    next_addr = addr;
    case (burst_t'(burst))
      BURST_INCR: next_addr = w_incr;
      BURST_WRAP: next_addr = (addr & ~w_mask) | (w_incr & w_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write path: one AW burst at a time, beats streamed to a memory port, then B.
// Optional wlast mismatch reporting is enabled by defining AXI4_WLAST_CHECK_EN.
module axi4_slave_write_responder
  import axi4_globals_pkg::*;
#(
  parameter int              ADDRESS_WIDTH = 32,
  parameter int              DATA_WIDTH    = 32,
  parameter longint unsigned MIN_ADDRESS   = 0,
  parameter longint unsigned MAX_ADDRESS   = 'h2FFF
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [15:0]               awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [15:0]               bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);
  localparam logic [2:0]               MAX_SIZE = 3'($clog2(DATA_WIDTH/8));
  localparam logic [ADDRESS_WIDTH-1:0] LO       = ADDRESS_WIDTH'(MIN_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] HI       = ADDRESS_WIDTH'(MAX_ADDRESS);

  // Single modular compare avoids a constant compare when MIN_ADDRESS is 0.
  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return (a - LO) <= (HI - LO);
  endfunction

  state_t                   r_state;
  logic                     r_awready, r_wready, r_bvalid, r_wr_en;
  logic [15:0]              r_bid;
  resp_t                    r_bresp;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [7:0]               r_len, r_cnt;
  logic [2:0]               r_size;
  burst_t                   r_burst;

  logic                     w_beat, w_is_last, w_slverr, w_decerr, w_wrap_bad;
  logic [ADDRESS_WIDTH-1:0] w_next_addr, w_span, w_wmask, w_last_addr;
  logic                     w_unused_wlast;

  assign w_unused_wlast = wlast;
  assign w_beat    = r_wready & wvalid;
  assign w_is_last = (r_cnt == r_len);

  // Burst legality and decode, evaluated on the raw AW fields.
  assign w_wrap_bad = (awburst == BURST_WRAP) &&
                      !(awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15);
  assign w_slverr   = (awburst == BURST_RESERVED) || (awsize > MAX_SIZE) || w_wrap_bad;
  assign w_span     = ADDRESS_WIDTH'(awlen) << awsize;
  assign w_wmask    = ((ADDRESS_WIDTH'(awlen) + ADDRESS_WIDTH'(1)) << awsize) - ADDRESS_WIDTH'(1);

  always_comb begin
    w_last_addr = awaddr;
    case (burst_t'(awburst))
      BURST_INCR: w_last_addr = awaddr + w_span;
      BURST_WRAP: w_last_addr = (awaddr & ~w_wmask) | ((awaddr + w_span) & w_wmask);
      default:    w_last_addr = awaddr;
    endcase
  end

  assign w_decerr = !in_range(awaddr) || !in_range(w_last_addr);

  axi4_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= BURST_FIXED;
    end else begin
      case (r_state)
        IDLE: begin
          r_awready <= 1'b1;
          if (awvalid && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= DATA;
            r_bid     <= awid;
            r_addr    <= awaddr;
            r_len     <= awlen;
            r_size    <= awsize;
            r_burst   <= burst_t'(awburst);
            r_cnt     <= '0;
            r_wr_en   <= !(w_decerr || w_slverr);
            r_bresp   <= w_decerr ? RESP_DECERR : (w_slverr ? RESP_SLVERR : RESP_OKAY);
          end
        end
        DATA: begin
          if (w_beat) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
`ifdef AXI4_WLAST_CHECK_EN
            if ((wlast != w_is_last) && (r_bresp == RESP_OKAY))
              r_bresp <= RESP_SLVERR;
`endif
            if (w_is_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign awready   = r_awready;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bid;
  assign bresp     = r_bresp;
  assign mem_we    = w_beat & r_wr_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_beat ? wdata : '0;
  assign mem_wstrb = w_beat ? wstrb : '0;

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed plus randomized bursts against an arithmetic model of the AXI4 write rules.
module tb_axi4_slave_write_responder;
  localparam logic [31:0] MAX_A = 32'h2FFF;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [15:0] bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axi4_slave_write_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MIN_ADDRESS(0), .MAX_ADDRESS('h2FFF)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte address of beat i, straight from the burst-type rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int sz,
                                            input int bt, input int i);
    longint bytes, tot, base, a64;
    bytes = longint'(1) << sz;
    tot   = longint'(len + 1) * bytes;
    a64   = longint'(a);
    case (bt)
      1: return 32'(a64 + longint'(i) * bytes);
      2: begin
        base = a64 - (a64 % tot);
        return 32'(base + ((a64 - base + longint'(i) * bytes) % tot));
      end
      default: return a;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"},  wready,  0);
    chk({tag, "_bvalid"},  bvalid,  0);
    chk({tag, "_mem_we"},  mem_we,  0);
    chk({tag, "_bid"},     bid,     0);
    chk({tag, "_bresp"},   bresp,   0);
    chk({tag, "_maddr"},   mem_addr, 0);
    chk({tag, "_mdata"},   mem_wdata, 0);
    chk({tag, "_mstrb"},   mem_wstrb, 0);
  endtask

  // Called at negedge+1 with the DUT idle. rst_beat >= 0 pulls reset when that beat is due.
  task automatic burst(input logic [15:0] id, input logic [31:0] a, input int len, input int sz,
                       input int bt, input int bad_last, input int bdelay, input int rst_beat);
    logic        dec, slv, wr_ok, took;
    logic [1:0]  exp_resp;
    logic [31:0] last;
    int          i, t;
    last  = beat_addr(a, len, sz, bt, len);
    dec   = (a > MAX_A) || (last > MAX_A);
    slv   = (bt == 3) || (sz > 2) || (bt == 2 && !(len inside {1, 3, 7, 15}));
    wr_ok = !dec && !slv;
`ifdef AXI4_WLAST_CHECK_EN
    if (bad_last >= 0 && bad_last <= len) slv = 1'b1;
`endif
    exp_resp = dec ? 2'd3 : (slv ? 2'd2 : 2'd0);

    awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(sz); awburst = 2'(bt); awvalid = 1'b1;
    wvalid = 1'b1; wdata = $urandom; wstrb = 4'($urandom);
    wlast = (len == 0) ^ (bad_last == 0);
    t = 0;
    #1;
    while (!awready && t < 50) begin @(negedge aclk); #1; t++; end
    chk("aw_ready", awready, 1);
    chk("w_stalled_in_idle", wready, 0);

    i = 0; t = 0; took = 1'b0;
    while (i <= len && t < 2000) begin
      @(negedge aclk);
      awvalid = 1'b0;
      t++;
      if (took) begin
        wdata = $urandom; wstrb = 4'($urandom);
        wlast = (i == len) ^ (i == bad_last);
        took  = 1'b0;
      end
      if (i == rst_beat) begin
        areset = 1'b1; wvalid = 1'b0;
        #1;
        check_reset_outputs("midburst_rst");
        return;
      end
      wvalid = ($urandom_range(0, 3) != 0);
      #1;
      chk("aw_w_exclusive", awready & wready, 0);
      if (wvalid && wready) begin
        chk("mem_we", mem_we, wr_ok);
        if (wr_ok) begin
          chk("mem_addr",  mem_addr,  beat_addr(a, len, sz, bt, i));
          chk("mem_wdata", mem_wdata, wdata);
          chk("mem_wstrb", mem_wstrb, wstrb);
        end
        chk("bvalid_early", bvalid, 0);
        i++;
        took = 1'b1;
      end else begin
        chk("mem_we_no_beat", mem_we, 0);
      end
    end
    if (i <= len) chk("w_timeout", i, len + 1);

    @(negedge aclk);
    wvalid = 1'b0;
    #1;
    chk("bvalid_after_last", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    chk("awready_in_resp", awready, 0);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge aclk); #1;
      chk("bvalid_hold", bvalid, 1);
      chk("bid_hold", bid, id);
      chk("bresp_hold", bresp, exp_resp);
      chk("awready_hold", awready, 0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    #1;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_after_b", awready, 1);
  endtask

  initial begin
    int bt, sz, len;
    logic [31:0] a;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_reset_outputs("reset");
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("awready_before_edge", awready, 0);
    @(negedge aclk); #1;
    chk("awready_first_edge", awready, 1);

    burst(16'h0001, 32'h100,  3, 2, 1, -1, 0, -1);  // INCR 0x100..0x10C
    burst(16'h0002, 32'h108,  3, 2, 2, -1, 1, -1);  // WRAP 0x108,0x10C,0x100,0x104
    burst(16'h0003, 32'h3000, 3, 2, 1, -1, 0, -1);  // start out of range
    burst(16'h0004, 32'h200,  1, 2, 1, -1, 5, -1);  // B backpressure
    burst(16'h0005, 32'h300,  2, 2, 3, -1, 0, -1);  // reserved burst
    burst(16'h0006, 32'h2FF8, 3, 2, 1, -1, 0, -1);  // final beat crosses MAX
    burst(16'h0007, 32'h400,  1, 3, 1, -1, 0, -1);  // oversize beat
    burst(16'h0008, 32'h400,  2, 2, 2, -1, 0, -1);  // illegal wrap length
    burst(16'h0009, 32'h200,  2, 2, 0, -1, 0, -1);  // FIXED
    burst(16'h000A, 32'hFFFFFFFC, 1, 2, 1, -1, 0, -1);  // INCR rolls over 2^32
    burst(16'h000B, 32'h2FFC, 0, 2, 1, -1, 2, -1);  // single beat at top
    burst(16'h000C, 32'h600,  3, 2, 1,  1, 0, -1);  // wlast early on beat 1

    for (int n = 0; n < 20; n++) begin
      bt  = $urandom_range(0, 2);
      sz  = $urandom_range(0, 2);
      len = (bt == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
      a   = 32'($urandom_range(0, 32'h3100)) & ~((32'd1 << sz) - 32'd1);
      burst(16'($urandom), a, len, sz, bt, -1, $urandom_range(0, 3), -1);
    end

    burst(16'h0BAD, 32'h500, 3, 2, 1, -1, 0, 2);  // reset during beat 2
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("post_rst_awready_low", awready, 0);
    @(negedge aclk); #1;
    chk("post_rst_awready", awready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk); #1;
      chk("post_rst_no_bvalid", bvalid, 0);
    end
    burst(16'h0010, 32'h700, 1, 2, 1, -1, 0, -1);  // clean burst after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
